// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : memory-wait FSM states (RUN, MEM_WAIT)
//   fwd_sel_t  : operand source select for EX (REGFILE, MEM, WB)
//   REG_ZERO   : architectural zero register; never a hazard source
//   reg_match  : true when two register ids match and are not r0
// -----------------------------------------------------------------------------
package dlx_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [1:0] {
        REGFILE = 2'b00,
        MEM     = 2'b01,
        WB      = 2'b10
    } fwd_sel_t;

    // r0 is hard-wired to zero, so a "match" on it is never a real dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a,
                                       input logic [REG_W-1:0] b);
        return (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Forwarding select for one EX source operand. The youngest producer (MEM)
// wins over the older one (WB); r0 never forwards.
//   rs            : source register of the EX instruction
//   rd_mem        : destination register in MEM, reg_write_mem its write flag
//   rd_wb         : destination register in WB,  reg_write_wb  its write flag
//   sel           : 00 regfile, 01 MEM ALU result, 10 WB result
// -----------------------------------------------------------------------------
module fwd_unit
    import dlx_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       reg_write_mem,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = REGFILE;
        if (reg_write_mem && reg_match(rd_mem, rs)) begin
            sel = MEM;
        end else if (reg_write_wb && reg_match(rd_wb, rs)) begin
            sel = WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: memory-wait stalls with timeout detection,
// load-use interlock, jump flushes and EX operand forwarding.
//   clk, reset                : clock and synchronous active-high reset
//   Rs1_ID/Rs2_ID, rs*_used_ID: ID-stage sources and their use flags
//   Rd_EX, d_load_enable_EX   : EX destination and EX-is-load flag
//   Rs1_EX/Rs2_EX             : EX sources for forwarding
//   Rd_MEM/Rd_WB, reg_write_* : later-stage writers
//   pc_cmd_EX, Pc_cmd_id      : jump taken in EX / in ID
//   d_req_MEM, d_ready        : data memory request in MEM / completion
//   stall_IF..stall_MEM       : hold stage registers
//   flush_IF, flush_ID        : nullify IF / ID instruction
//   bubble_EX                 : inject NOP into EX
//   fwd_S1_EX, fwd_S2_EX      : operand source selects
//   mem_error                 : sticky memory timeout flag
//   stall_cnt                 : saturating count of cycles with stall_IF=1
// All control outputs are combinational; only the FSM state, the wait
// counter, mem_error and stall_cnt are registered.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             d_load_enable_EX,
    input  logic [4:0]       Rs1_EX,
    input  logic [4:0]       Rs2_EX,
    input  logic [4:0]       Rd_MEM,
    input  logic [4:0]       Rd_WB,
    input  logic             reg_write_MEM,
    input  logic             reg_write_WB,
    input  logic             pc_cmd_EX,
    input  logic             Pc_cmd_id,
    input  logic             d_req_MEM,
    input  logic             d_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             bubble_EX,
    output logic [1:0]       fwd_S1_EX,
    output logic [1:0]       fwd_S2_EX,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_error_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic mem_stall;
    logic jump_ex;
    logic load_use;
    logic jump_id;

    // ------------------------------------------------------------------
    // Hazard detection, in priority order:
    //   memory stall > EX jump > load-use > ID jump
    // ------------------------------------------------------------------
    always_comb begin
        mem_stall = 1'b0;
        if (!reset) begin
            case (state_reg)
                RUN:      mem_stall = d_req_MEM && !d_ready;
                // Once waiting, only d_ready releases the pipeline; the
                // request line is not re-examined.
                MEM_WAIT: mem_stall = !d_ready;
                default:  mem_stall = 1'b0;
            endcase
        end
    end

    logic rs1_dep;
    logic rs2_dep;

    always_comb begin
        rs1_dep  = rs1_used_ID && reg_match(Rd_EX, Rs1_ID);
        rs2_dep  = rs2_used_ID && reg_match(Rd_EX, Rs2_ID);

        jump_ex  = !reset && !mem_stall && pc_cmd_EX;
        // A taken EX jump kills the dependent ID instruction anyway, so
        // there is nothing to interlock on.
        load_use = !reset && !mem_stall && !pc_cmd_EX &&
                   d_load_enable_EX && (rs1_dep || rs2_dep);
        jump_id  = !reset && !mem_stall && !pc_cmd_EX && !load_use &&
                   Pc_cmd_id;
    end

    // ------------------------------------------------------------------
    // Stage control outputs
    // ------------------------------------------------------------------
    logic [3:0] stall_vec;

    // Front two stages also hold for load-use; back two only for memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stall
            if (gi < 2) begin : g_front
                assign stall_vec[gi] = mem_stall || load_use;
            end else begin : g_back
                assign stall_vec[gi] = mem_stall;
            end
        end
    endgenerate

    assign stall_IF  = stall_vec[0];
    assign stall_ID  = stall_vec[1];
    assign stall_EX  = stall_vec[2];
    assign stall_MEM = stall_vec[3];

    assign flush_IF  = jump_ex || jump_id;
    assign flush_ID  = jump_ex;
    assign bubble_EX = jump_ex || load_use;

    // ------------------------------------------------------------------
    // Forwarding: one fwd_unit per EX source operand
    // ------------------------------------------------------------------
    logic [4:0] fwd_src [2];
    logic [1:0] fwd_raw [2];

    assign fwd_src[0] = Rs1_EX;
    assign fwd_src[1] = Rs2_EX;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .rs            (fwd_src[gi]),
                .rd_mem        (Rd_MEM),
                .reg_write_mem (reg_write_MEM),
                .rd_wb         (Rd_WB),
                .reg_write_wb  (reg_write_WB),
                .sel           (fwd_raw[gi])
            );
        end
    endgenerate

    assign fwd_S1_EX = reset ? 2'b00 : fwd_raw[0];
    assign fwd_S2_EX = reset ? 2'b00 : fwd_raw[1];

    // ------------------------------------------------------------------
    // FSM, wait counter, timeout flag and stall statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            mem_error_reg <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (d_req_MEM && !d_ready) begin
                        state_reg <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (d_ready) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase

            // The wait length includes the cycle in which the request was
            // first refused; the counter parks at the limit so it cannot
            // wrap during a very long wait.
            if (mem_stall) begin
                if (wait_cnt_reg != WAIT_LIMIT) begin
                    wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                end
                if (wait_cnt_reg >= WAIT_LAST) begin
                    mem_error_reg <= 1'b1;
                end
            end else begin
                wait_cnt_reg <= '0;
            end

            if (stall_IF && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign mem_error = mem_error_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a constant vector table for the
// combinational decisions, hand-written multi-cycle sequences for the
// memory-wait / timeout / reset corners, then random stimulus against a
// behavioural model. stall_cnt is narrowed to 4 bits so saturation is reached.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int TIMEOUT  = 16;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [4:0]          Rs1_ID, Rs2_ID, Rd_EX, Rs1_EX, Rs2_EX, Rd_MEM, Rd_WB;
    logic                rs1_used_ID, rs2_used_ID, d_load_enable_EX;
    logic                reg_write_MEM, reg_write_WB, pc_cmd_EX, Pc_cmd_id;
    logic                d_req_MEM, d_ready;
    logic                stall_IF, stall_ID, stall_EX, stall_MEM;
    logic                flush_IF, flush_ID, bubble_EX;
    logic [1:0]          fwd_S1_EX, fwd_S2_EX;
    logic                mem_error;
    logic [TB_CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Rs1_ID           (Rs1_ID),
        .Rs2_ID           (Rs2_ID),
        .rs1_used_ID      (rs1_used_ID),
        .rs2_used_ID      (rs2_used_ID),
        .Rd_EX            (Rd_EX),
        .d_load_enable_EX (d_load_enable_EX),
        .Rs1_EX           (Rs1_EX),
        .Rs2_EX           (Rs2_EX),
        .Rd_MEM           (Rd_MEM),
        .Rd_WB            (Rd_WB),
        .reg_write_MEM    (reg_write_MEM),
        .reg_write_WB     (reg_write_WB),
        .pc_cmd_EX        (pc_cmd_EX),
        .Pc_cmd_id        (Pc_cmd_id),
        .d_req_MEM        (d_req_MEM),
        .d_ready          (d_ready),
        .stall_IF         (stall_IF),
        .stall_ID         (stall_ID),
        .stall_EX         (stall_EX),
        .stall_MEM        (stall_MEM),
        .flush_IF         (flush_IF),
        .flush_ID         (flush_ID),
        .bubble_EX        (bubble_EX),
        .fwd_S1_EX        (fwd_S1_EX),
        .fwd_S2_EX        (fwd_S2_EX),
        .mem_error        (mem_error),
        .stall_cnt        (stall_cnt)
    );

    typedef struct {
        logic [4:0] rs1_id, rs2_id;
        logic       u1, u2;
        logic [4:0] rd_ex;
        logic       ld;
        logic [4:0] rs1_ex, rs2_ex, rd_mem, rd_wb;
        logic       wm, ww, pc_ex, pc_id, dreq, drdy;
    } in_t;

    // stl = {stall_IF, stall_ID, stall_EX, stall_MEM}
    // fl  = {flush_IF, flush_ID, bubble_EX}
    typedef struct {
        logic [3:0] stl;
        logic [2:0] fl;
        logic [1:0] f1, f2;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    in_t  idle_in;
    out_t zero_out;

    // ---------------- helpers ----------------
    task automatic drive(input in_t v);
        Rs1_ID = v.rs1_id;  Rs2_ID = v.rs2_id;
        rs1_used_ID = v.u1; rs2_used_ID = v.u2;
        Rd_EX = v.rd_ex;    d_load_enable_EX = v.ld;
        Rs1_EX = v.rs1_ex;  Rs2_EX = v.rs2_ex;
        Rd_MEM = v.rd_mem;  Rd_WB = v.rd_wb;
        reg_write_MEM = v.wm; reg_write_WB = v.ww;
        pc_cmd_EX = v.pc_ex;  Pc_cmd_id = v.pc_id;
        d_req_MEM = v.dreq;   d_ready = v.drdy;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, ".stall"}, int'({stall_IF, stall_ID, stall_EX, stall_MEM}), int'(e.stl));
        chk({tag, ".flush"}, int'({flush_IF, flush_ID, bubble_EX}), int'(e.fl));
        chk({tag, ".fwd1"},  int'(fwd_S1_EX), int'(e.f1));
        chk({tag, ".fwd2"},  int'(fwd_S2_EX), int'(e.f2));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(idle_in);
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic out_t mk(input logic [3:0] s, input logic [2:0] f,
                                input logic [1:0] a, input logic [1:0] b);
        out_t o;
        o.stl = s; o.fl = f; o.f1 = a; o.f2 = b;
        return o;
    endfunction

    // ---------------- behavioural reference model ----------------
    bit m_wait;   // a data access is outstanding and unanswered
    int m_run;    // length of the current unanswered-access streak
    bit m_err;
    int m_cnt;

    function automatic logic [1:0] src_of(input logic [4:0] rs, input in_t v);
        if (rs == 0) return 2'b00;
        if (v.wm && v.rd_mem == rs) return 2'b01;
        if (v.ww && v.rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic out_t model(input in_t v, input bit rst, output bit blocked);
        out_t o;
        bit   lu;
        o = mk(4'b0, 3'b0, 2'b0, 2'b0);
        blocked = 1'b0;
        if (rst) return o;
        blocked = !v.drdy && (m_wait || v.dreq);
        lu = v.ld && (v.rd_ex != 0) &&
             ((v.u1 && v.rs1_id == v.rd_ex) || (v.u2 && v.rs2_id == v.rd_ex));
        if (blocked)      o.stl = 4'b1111;
        else if (v.pc_ex) o.fl  = 3'b111;
        else if (lu)      begin o.stl = 4'b1100; o.fl = 3'b001; end
        else if (v.pc_id) o.fl  = 3'b100;
        o.f1 = src_of(v.rs1_ex, v);
        o.f2 = src_of(v.rs2_ex, v);
        return o;
    endfunction

    task automatic model_edge(input bit rst, input bit blocked, input bit stalled);
        if (rst) begin
            m_wait = 0; m_run = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (blocked) begin
                m_run++;
                if (m_run >= TIMEOUT) m_err = 1;
            end else begin
                m_run = 0;
            end
            m_wait = blocked;
            if (stalled && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    // ---------------- vector table ----------------
    vec_t tbl [14];

    task automatic fill_table();
        for (int k = 0; k < 14; k++) begin
            tbl[k].i = idle_in;
            tbl[k].o = zero_out;
        end
        // load r3 in EX, ID reads r3 through Rs1
        tbl[1].i.rs1_id = 3; tbl[1].i.u1 = 1; tbl[1].i.rd_ex = 3; tbl[1].i.ld = 1;
        tbl[1].o = mk(4'b1100, 3'b001, 0, 0);
        // dependency through Rs2
        tbl[2].i.rs2_id = 9; tbl[2].i.u2 = 1; tbl[2].i.rd_ex = 9; tbl[2].i.ld = 1;
        tbl[2].o = mk(4'b1100, 3'b001, 0, 0);
        // matching id but source not used
        tbl[3].i.rs1_id = 3; tbl[3].i.rd_ex = 3; tbl[3].i.ld = 1;
        // r0 never interlocks
        tbl[4].i.u1 = 1; tbl[4].i.u2 = 1; tbl[4].i.ld = 1;
        // EX jump with a load-use hit: flush wins, no stall
        tbl[5].i = tbl[1].i; tbl[5].i.pc_ex = 1;
        tbl[5].o = mk(4'b0000, 3'b111, 0, 0);
        // ID jump alone
        tbl[6].i.pc_id = 1;
        tbl[6].o = mk(4'b0000, 3'b100, 0, 0);
        // ID jump under a load-use hit: load-use wins
        tbl[7].i = tbl[1].i; tbl[7].i.pc_id = 1;
        tbl[7].o = mk(4'b1100, 3'b001, 0, 0);
        // memory stall masks EX jump and load-use
        tbl[8].i = tbl[1].i; tbl[8].i.pc_ex = 1; tbl[8].i.dreq = 1; tbl[8].i.drdy = 0;
        tbl[8].o = mk(4'b1111, 3'b000, 0, 0);
        // request answered in the same cycle: no stall
        tbl[9].i.dreq = 1; tbl[9].i.pc_id = 1;
        tbl[9].o = mk(4'b0000, 3'b100, 0, 0);
        // MEM and WB both write r7: MEM wins
        tbl[10].i.rd_mem = 7; tbl[10].i.rd_wb = 7; tbl[10].i.rs1_ex = 7; tbl[10].i.rs2_ex = 7;
        tbl[10].i.wm = 1; tbl[10].i.ww = 1;
        tbl[10].o = mk(0, 0, 2'b01, 2'b01);
        // r0 in MEM never forwards; WB supplies Rs2
        tbl[11].i.wm = 1; tbl[11].i.ww = 1; tbl[11].i.rd_wb = 5; tbl[11].i.rs2_ex = 5;
        tbl[11].o = mk(0, 0, 2'b00, 2'b10);
        // MEM not writing: fall back to WB
        tbl[12].i.rd_mem = 4; tbl[12].i.rd_wb = 4; tbl[12].i.ww = 1;
        tbl[12].i.rs1_ex = 4; tbl[12].i.rs2_ex = 4;
        tbl[12].o = mk(0, 0, 2'b10, 2'b10);
        // EX instruction is not a load
        tbl[13].i.rs1_id = 6; tbl[13].i.u1 = 1; tbl[13].i.rd_ex = 6;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        in_t  v;
        out_t e;
        bit   blk, rst;
        int   busy;

        idle_in = '{default: '0};
        idle_in.drdy = 1'b1;
        zero_out = mk(0, 0, 0, 0);

        // Reset holds all controls low even under hazardous inputs.
        reset = 1'b1;
        v = idle_in;
        v.rs1_id = 3; v.u1 = 1; v.rd_ex = 3; v.ld = 1; v.pc_ex = 1;
        v.dreq = 1; v.drdy = 0; v.rd_mem = 7; v.rs1_ex = 7; v.wm = 1;
        drive(v);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_out("reset_hold", zero_out);
        chk("reset_cnt", int'(stall_cnt), 0);
        chk("reset_err", int'(mem_error), 0);
        next_cycle();
        drive(idle_in);
        reset = 1'b0;
        @(negedge clk);
        chk_out("after_reset", zero_out);

        // Table
        fill_table();
        for (int k = 0; k < 14; k++) begin
            do_reset();
            drive(tbl[k].i);
            @(negedge clk);
            chk_out($sformatf("vec%0d", k), tbl[k].o);
            next_cycle();
        end

        // Single load-use cycle then the bubble: one stalled cycle counted.
        do_reset();
        v = idle_in; v.rs1_id = 3; v.u1 = 1; v.rd_ex = 3; v.ld = 1;
        drive(v);
        @(negedge clk);
        chk_out("lu_cycle", mk(4'b1100, 3'b001, 0, 0));
        next_cycle();
        drive(idle_in);
        @(negedge clk);
        chk_out("lu_after", zero_out);
        chk("lu_cnt", int'(stall_cnt), 1);

        // Five refused cycles then ready.
        do_reset();
        v = idle_in; v.dreq = 1; v.drdy = 0;
        drive(v);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("mw5_stall_c%0d", c),
                int'({stall_IF, stall_ID, stall_EX, stall_MEM}), 15);
            next_cycle();
        end
        d_ready = 1'b1;
        @(negedge clk);
        chk("mw5_ready_stall", int'({stall_IF, stall_ID, stall_EX, stall_MEM}), 0);
        next_cycle();
        drive(idle_in);
        @(negedge clk);
        chk("mw5_cnt", int'(stall_cnt), 5);
        chk("mw5_run", int'(stall_IF), 0);

        // Timeout: 20 refused cycles, error visible from cycle index 16.
        do_reset();
        v = idle_in; v.dreq = 1; v.drdy = 0;
        drive(v);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("to_err_c%0d", c), int'(mem_error), (c >= TIMEOUT) ? 1 : 0);
            chk($sformatf("to_stall_c%0d", c), int'(stall_MEM), 1);
            next_cycle();
        end
        d_ready = 1'b1;
        @(negedge clk);
        chk("to_ready_stall", int'(stall_IF), 0);
        chk("to_ready_err", int'(mem_error), 1);
        next_cycle();
        drive(idle_in);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("to_sticky_err", int'(mem_error), 1);
        chk("to_cnt_sat", int'(stall_cnt), CNT_MAX);
        do_reset();
        @(negedge clk);
        chk("to_cleared_err", int'(mem_error), 0);

        // Reset in the third MEM_WAIT cycle.
        do_reset();
        v = idle_in; v.dreq = 1; v.drdy = 0;
        drive(v);
        for (int c = 0; c < 3; c++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk_out("rst_in_wait_hold", zero_out);
        next_cycle();
        reset = 1'b0;
        drive(idle_in);
        @(negedge clk);
        chk_out("rst_in_wait_after", zero_out);
        chk("rst_in_wait_cnt", int'(stall_cnt), 0);
        chk("rst_in_wait_err", int'(mem_error), 0);
        next_cycle();
        @(negedge clk);
        chk_out("rst_in_wait_run", zero_out);

        // Random stimulus against the model.
        do_reset();
        m_wait = 0; m_run = 0; m_err = 0; m_cnt = 0;
        busy = 0;
        for (int c = 0; c < 1500; c++) begin
            v.rs1_id = 5'($urandom_range(0, 3));
            v.rs2_id = 5'($urandom_range(0, 3));
            v.u1     = 1'($urandom_range(0, 1));
            v.u2     = 1'($urandom_range(0, 1));
            v.rd_ex  = 5'($urandom_range(0, 3));
            v.ld     = 1'($urandom_range(0, 1));
            v.rs1_ex = 5'($urandom_range(0, 3));
            v.rs2_ex = 5'($urandom_range(0, 3));
            v.rd_mem = 5'($urandom_range(0, 3));
            v.rd_wb  = 5'($urandom_range(0, 3));
            v.wm     = 1'($urandom_range(0, 1));
            v.ww     = 1'($urandom_range(0, 1));
            v.pc_ex  = ($urandom_range(0, 5) == 0);
            v.pc_id  = ($urandom_range(0, 4) == 0);
            v.dreq   = ($urandom_range(0, 2) == 0);
            if (busy == 0 && $urandom_range(0, 40) == 0) busy = 18;
            if (busy > 0) begin
                v.drdy = 1'b0;
                busy--;
            end else begin
                v.drdy = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 150) == 0);
            reset = rst;
            drive(v);
            e = model(v, rst, blk);
            @(negedge clk);
            chk_out($sformatf("rnd%0d", c), e);
            chk($sformatf("rnd%0d.err", c), int'(mem_error), int'(m_err));
            chk($sformatf("rnd%0d.cnt", c), int'(stall_cnt), m_cnt);
            next_cycle();
            model_edge(rst, blk, e.stl[3]);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
